nios2_ram_pipelined: RTL and testbench

//  Parametrised on-chip RAM for the NIOS2 system: Avalon-MM pipelined slave with byte enables.

---
 rtl/nios2_ram_pkg.sv | 22 ++
 rtl/nios2_ram_pipelined_if.sv | 27 ++
 rtl/nios2_ram_array.sv | 34 +++
 rtl/nios2_ram_pipelined.sv | 174 +++++++++++++++++
 tb/tb_nios2_ram_pipelined.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/nios2_ram_pkg.sv
// Shared types, constants and helpers for the pipelined NIOS2 on-chip RAM.
package nios2_ram_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

  // Elaboration-time legality of the parameter set; checked by the top.
  function automatic bit cfg_ok(input int dw, input int depth, input int aw, input int rl);
    return (dw > 0) && (dw % 8 == 0) && (depth > 0) && (aw > 0) && (aw < 31) &&
           ((1 << aw) >= depth) && (rl >= READ_LATENCY_MIN) && (rl <= READ_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/nios2_ram_pipelined_if.sv
// Avalon-MM pipelined slave bundle for the NIOS2 on-chip RAM.
interface nios2_ram_pipelined_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;
  logic                    init_done;
  logic                    readerror;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest, init_done, readerror
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest, init_done, readerror
  );
endinterface

// File: rtl/nios2_ram_array.sv
// Byte-lane-enabled single-port storage with a registered read port.
// Lanes are LANE_W wide so a parity bit can ride along with each byte.
module nios2_ram_array #(
  parameter int NB         = 4,
  parameter int LANE_W     = 8,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic                         we,
  input  logic [NB-1:0]                be,
  input  logic [NB-1:0][LANE_W-1:0]    wlanes,
  input  logic                         re,
  output logic [NB-1:0][LANE_W-1:0]    rlanes
);

  logic [NB-1:0][LANE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][i] <= wlanes[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rlanes <= '0;
    else if (re)   rlanes <= mem[addr];
  end

endmodule

// File: rtl/nios2_ram_pipelined.sv
// Pipelined Avalon-MM RAM with post-reset zero-fill and 1|2-cycle read latency.
// Define NIOS2_RAM_PARITY_EN to store and check one even-parity bit per byte lane.
//
//  state    | meaning
//  ST_FILL  | zero-filling (ZERO_INIT=1) or one-cycle post-reset hold; waitrequest=1
//  ST_READY | accepting one command per cycle; waitrequest=0
module nios2_ram_pipelined
  import nios2_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 20480,
  parameter int ADDR_WIDTH   = 15,
  parameter int READ_LATENCY = 1,
  parameter int ZERO_INIT    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  nios2_ram_pipelined_if.slave  bus
);

  localparam int NB = DATA_WIDTH / 8;
`ifdef NIOS2_RAM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif

  if (!cfg_ok(DATA_WIDTH, DEPTH, ADDR_WIDTH, READ_LATENCY)) begin : g_bad_cfg
    $error("nios2_ram_pipelined: illegal DATA_WIDTH/DEPTH/ADDR_WIDTH/READ_LATENCY");
  end

  state_t                    state, state_nx;
  logic [ADDR_WIDTH-1:0]     fill_cnt;
  logic                      fill_last, fill_we;
  logic                      waitreq, ready;
  logic                      acc, wr_acc, rd_acc, in_range;
  logic [ADDR_WIDTH-1:0]     a_addr;
  logic                      a_we, a_re;
  logic [NB-1:0]             a_be;
  logic [NB-1:0][LANE_W-1:0] a_wlanes, a_rlanes;
  logic [DATA_WIDTH-1:0]     rd_word;
  logic                      lane_err;
  logic                      v1, oor1;
  logic [DATA_WIDTH-1:0]     data1;
  logic                      err1;
  logic                      rdv_out, rerr_out;
  logic [DATA_WIDTH-1:0]     rdata_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_FILL;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_FILL:  if ((ZERO_INIT == 0) || fill_last) state_nx = ST_READY;
      ST_READY: state_nx = ST_READY;
      default:  state_nx = ST_FILL;
    endcase
  end

  always_comb begin
    waitreq = 1'b1;
    ready   = 1'b0;
    if (state == ST_READY) begin
      waitreq = 1'b0;
      ready   = 1'b1;
    end
  end

  assign fill_last = (fill_cnt == ADDR_WIDTH'(DEPTH - 1));
  assign fill_we   = (state == ST_FILL) && (ZERO_INIT != 0);

  // Counter parks at DEPTH-1 so it never addresses past the array.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 fill_cnt <= '0;
    else if (fill_we && !fill_last) fill_cnt <= fill_cnt + ADDR_WIDTH'(1);
  end

  assign acc      = bus.chipselect & (bus.read | bus.write) & ~waitreq;
  assign wr_acc   = acc & bus.write;
  assign rd_acc   = acc & bus.read & ~bus.write;
  assign in_range = ({1'b0, bus.address} < (ADDR_WIDTH + 1)'(DEPTH));

  assign a_addr = fill_we ? fill_cnt : bus.address;
  assign a_we   = fill_we | (wr_acc & in_range);
  assign a_be   = fill_we ? '1 : bus.byteenable;
  assign a_re   = rd_acc & in_range;

  always_comb begin
    a_wlanes = '0;
    for (int i = 0; i < NB; i++) begin
`ifdef NIOS2_RAM_PARITY_EN
      a_wlanes[i] = fill_we ? '0 : {byte_parity(bus.writedata[8*i +: 8]), bus.writedata[8*i +: 8]};
`else
      a_wlanes[i] = fill_we ? '0 : bus.writedata[8*i +: 8];
`endif
    end
  end

  nios2_ram_array #(
    .NB         (NB),
    .LANE_W     (LANE_W),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (a_addr),
    .we      (a_we),
    .be      (a_be),
    .wlanes  (a_wlanes),
    .re      (a_re),
    .rlanes  (a_rlanes)
  );

  always_comb begin
    rd_word  = '0;
    lane_err = 1'b0;
    for (int i = 0; i < NB; i++) begin
      rd_word[8*i +: 8] = a_rlanes[i][7:0];
`ifdef NIOS2_RAM_PARITY_EN
      lane_err = lane_err | (a_rlanes[i][8] != byte_parity(a_rlanes[i][7:0]));
`endif
    end
  end

  // Out-of-range flag travels with the read so the word can be masked to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1   <= 1'b0;
      oor1 <= 1'b0;
    end else begin
      v1 <= rd_acc;
      if (rd_acc) oor1 <= ~in_range;
    end
  end

  assign data1 = oor1 ? '0 : rd_word;
  assign err1  = ~oor1 & lane_err;

  if (READ_LATENCY == 1) begin : g_lat1
    assign rdv_out   = v1;
    assign rdata_out = data1;
    assign rerr_out  = err1;
  end else begin : g_lat2
    logic                  v2, err2;
    logic [DATA_WIDTH-1:0] data2;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v2    <= 1'b0;
        err2  <= 1'b0;
        data2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) begin
          err2  <= err1;
          data2 <= data1;
        end
      end
    end
    assign rdv_out   = v2;
    assign rdata_out = data2;
    assign rerr_out  = err2;
  end

  assign bus.readdata      = rdata_out;
  assign bus.readdatavalid = rdv_out;
  assign bus.readerror     = rdv_out & rerr_out;
  assign bus.waitrequest   = waitreq;
  assign bus.init_done     = ready;

endmodule

// File: tb/tb_nios2_ram_pipelined.sv
// Directed bench: instance A (DEPTH=64, latency 1, zero-fill), instance B (DEPTH=48, latency 2, no fill).
module tb_nios2_ram_pipelined;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  nios2_ram_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) ba();
  nios2_ram_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) bb();

  nios2_ram_pipelined #(.DATA_WIDTH(32), .DEPTH(64), .ADDR_WIDTH(6),
                        .READ_LATENCY(1), .ZERO_INIT(1))
    dut_a (.clk(clk), .reset_n(rst_a), .bus(ba));

  nios2_ram_pipelined #(.DATA_WIDTH(32), .DEPTH(48), .ADDR_WIDTH(6),
                        .READ_LATENCY(2), .ZERO_INIT(0))
    dut_b (.clk(clk), .reset_n(rst_b), .bus(bb));

  typedef struct {
    logic        cs, rd, wr;
    logic [5:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_a(input logic cs, input logic rd, input logic wr,
                         input logic [5:0] addr, input logic [3:0] be, input logic [31:0] wd);
    ba.chipselect = cs; ba.read = rd; ba.write = wr;
    ba.address = addr; ba.byteenable = be; ba.writedata = wd;
  endtask

  task automatic drive_b(input logic cs, input logic rd, input logic wr,
                         input logic [5:0] addr, input logic [3:0] be, input logic [31:0] wd);
    bb.chipselect = cs; bb.read = rd; bb.write = wr;
    bb.address = addr; bb.byteenable = be; bb.writedata = wd;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    logic        ev;
    logic [31:0] ed;
    logic        exp_err;

    vecs[0]  = '{1, 0, 1, 6'd3, 4'hF, 32'hAABBCCDD, 0, 32'h0};
    vecs[1]  = '{1, 0, 1, 6'd3, 4'h5, 32'h11223344, 0, 32'h0};
    vecs[2]  = '{1, 1, 0, 6'd3, 4'h0, 32'h0,        1, 32'hAA22CC44};
    vecs[3]  = '{1, 0, 1, 6'd3, 4'h0, 32'hFFFFFFFF, 0, 32'hAA22CC44};
    vecs[4]  = '{1, 1, 0, 6'd3, 4'h0, 32'h0,        1, 32'hAA22CC44};
    vecs[5]  = '{1, 0, 1, 6'd7, 4'hA, 32'h55667788, 0, 32'hAA22CC44};
    vecs[6]  = '{1, 1, 0, 6'd7, 4'h0, 32'h0,        1, 32'h55007700};
    vecs[7]  = '{1, 1, 1, 6'd8, 4'hF, 32'hCAFEF00D, 0, 32'h55007700};
    vecs[8]  = '{1, 1, 0, 6'd8, 4'h0, 32'h0,        1, 32'hCAFEF00D};
    vecs[9]  = '{0, 0, 1, 6'd8, 4'hF, 32'h0,        0, 32'hCAFEF00D};
    vecs[10] = '{1, 1, 0, 6'd8, 4'h0, 32'h0,        1, 32'hCAFEF00D};
    vecs[11] = '{0, 1, 0, 6'd8, 4'h0, 32'h0,        0, 32'hCAFEF00D};

    drive_a(0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    chk("a_rst_readdata", ba.readdata, 32'h0);
    chk("a_rst_valid", {31'b0, ba.readdatavalid}, 32'h0);
    chk("a_rst_waitreq", {31'b0, ba.waitrequest}, 32'h1);
    chk("a_rst_init_done", {31'b0, ba.init_done}, 32'h0);
    chk("a_rst_readerror", {31'b0, ba.readerror}, 32'h0);
    chk("b_rst_waitreq", {31'b0, bb.waitrequest}, 32'h1);
    chk("b_rst_init_done", {31'b0, bb.init_done}, 32'h0);

    // Zero-fill: waitrequest stays high for DEPTH cycles after release.
    rst_a = 1'b1;
    #1;
    n = 0;
    while (ba.waitrequest && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("a_fill_cycles", n, 64);
    chk("a_init_done", {31'b0, ba.init_done}, 32'h1);

    seen = 0;
    for (int i = 0; i < 64; i++) begin
      drive_a(1, 1, 0, 6'(i), 4'h0, 32'h0);
      @(negedge clk);
      if (!ba.readdatavalid || ba.readdata !== 32'h0 || ba.readerror) seen++;
    end
    chk("a_zero_fill_bad_words", seen, 0);

    for (int i = 0; i < 12; i++) begin
      drive_a(vecs[i].cs, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wdata);
      @(negedge clk);
      chk($sformatf("a_vec%0d_valid", i), {31'b0, ba.readdatavalid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("a_vec%0d_data", i), ba.readdata, vecs[i].exp_data);
    end
    drive_a(0, 0, 0, 0, 0, 0);

    // Parity: corrupt lane 1 of word 5 behind the bus.
`ifdef NIOS2_RAM_PARITY_EN
    dut_a.u_array.mem[5][1][8] = ~dut_a.u_array.mem[5][1][8];
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    drive_a(1, 1, 0, 6'd5, 4'h0, 32'h0);
    @(negedge clk);
    chk("a_par5_valid", {31'b0, ba.readdatavalid}, 32'h1);
    chk("a_par5_err", {31'b0, ba.readerror}, {31'b0, exp_err});
    drive_a(1, 1, 0, 6'd6, 4'h0, 32'h0);
    @(negedge clk);
    chk("a_par6_err", {31'b0, ba.readerror}, 32'h0);
    drive_a(0, 0, 0, 0, 0, 0);

    // Instance B: no fill, ready one cycle after release.
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    chk("b_rel_waitreq", {31'b0, bb.waitrequest}, 32'h1);
    @(negedge clk);
    chk("b_ready_waitreq", {31'b0, bb.waitrequest}, 32'h0);
    chk("b_ready_init_done", {31'b0, bb.init_done}, 32'h1);

    for (int i = 0; i < 8; i++) begin
      drive_b(1, 0, 1, 6'(i), 4'hF, 32'h1000 + 32'(i));
      @(negedge clk);
    end
    drive_b(1, 0, 1, 6'd9, 4'hF, 32'h12345678);
    @(negedge clk);

    // Eight back-to-back reads, latency 2: valids in iterations 1..8.
    for (int c = 0; c < 11; c++) begin
      if (c < 8) drive_b(1, 1, 0, 6'(c), 4'h0, 32'h0);
      else       drive_b(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      ev = (c >= 1 && c <= 8);
      ed = (c == 0) ? 32'h0 : ((c <= 8) ? 32'h1000 + 32'(c - 1) : 32'h1007);
      chk($sformatf("b_pipe%0d_valid", c), {31'b0, bb.readdatavalid}, {31'b0, ev});
      chk($sformatf("b_pipe%0d_data", c), bb.readdata, ed);
    end

    drive_b(1, 1, 0, 6'd48, 4'h0, 32'h0);
    @(negedge clk);
    drive_b(0, 0, 0, 0, 0, 0);
    chk("b_oor_early_valid", {31'b0, bb.readdatavalid}, 32'h0);
    @(negedge clk);
    chk("b_oor_valid", {31'b0, bb.readdatavalid}, 32'h1);
    chk("b_oor_data", bb.readdata, 32'h0);
    chk("b_oor_err", {31'b0, bb.readerror}, 32'h0);

    // Reset with both latency stages occupied.
    drive_b(1, 1, 0, 6'd9, 4'h0, 32'h0);
    @(negedge clk);
    drive_b(1, 1, 0, 6'd0, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    drive_b(0, 0, 0, 0, 0, 0);
    rst_b = 1'b0;
    #1;
    chk("b_rst_valid", {31'b0, bb.readdatavalid}, 32'h0);
    chk("b_rst_readdata", bb.readdata, 32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    drive_b(1, 1, 0, 6'd9, 4'h0, 32'h0);
    #1;
    chk("b_rerel_waitreq", {31'b0, bb.waitrequest}, 32'h1);
    @(negedge clk);
    drive_b(0, 0, 0, 0, 0, 0);
    chk("b_rerel_ready", {31'b0, bb.waitrequest}, 32'h0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bb.readdatavalid) seen++;
    end
    chk("b_post_reset_valids", seen, 0);

    drive_b(1, 1, 0, 6'd9, 4'h0, 32'h0);
    @(negedge clk);
    drive_b(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("b_retain_valid", {31'b0, bb.readdatavalid}, 32'h1);
    chk("b_retain_data", bb.readdata, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
